sv_stream_mem: RTL and testbench
================================

Name: sv_stream_mem

Overview:
- Parametrised support-vector store for the SVM stress-detection datapath, replacing the single-port tri-state RAM with separate write and read ports.
- Holds NUM_SV vectors of NUM_FEAT features each.
- On a start command, streams one whole vector to the kernel engine, LANES features per beat, using a valid/ready handshake with backpressure and a last-beat flag.
- Sits between the host/config loader (write side) and the kernel/dot-product unit (read side).

Parameters:
- DATA_WIDTH, 32: width of one feature word.
- NUM_SV, 16: number of support vectors stored.
- NUM_FEAT, 8: features per vector. Must be a multiple of LANES.
- LANES, 2: features delivered per output beat.
- SV_W, $clog2(NUM_SV): derived width of the vector index.
- FEAT_W, $clog2(NUM_FEAT): derived width of the feature index.
- BEATS, NUM_FEAT/LANES: derived number of beats per vector.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_sv  input  SV_W  vector index for the write.
- wr_feat  input  FEAT_W  feature index for the write.
- wr_data  input  DATA_WIDTH  write data.
- rd_start  input  1  start-stream request.
- rd_sv  input  SV_W  vector to stream. Sampled with rd_start.
- busy  output  1  stream in progress.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_last  output  1  current beat is the final beat of the vector.
- err_range  output  1  one-cycle pulse on a rejected out-of-range command.

Behaviour:
- Storage: LANES banks. Feature f of vector s lives in bank f%LANES, row s*BEATS + f/LANES.
  - Each bank has 1 write and 1 read port, synchronous, 1-cycle read latency.
  - No reset on the array; contents survive rst.
- Write: wr_en with wr_sv<NUM_SV and wr_feat<NUM_FEAT writes on the clock edge.
  - An out-of-range write is dropped and err_range=1 the next cycle.
  - Writes are accepted in any state, including mid-stream.
- Read-during-write to the same bank row in the same cycle returns the OLD data.
- Handshake: a beat transfers on a cycle where out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data and out_last are held stable.
- FSM: IDLE, RUN.
  - IDLE:
    - rd_start with rd_sv<NUM_SV: latch rd_sv, issue the beat-0 read in the same cycle, go to RUN. busy=1 from the next cycle.
    - rd_start with rd_sv>=NUM_SV: rejected, err_range=1 the next cycle, stay in IDLE.
  - RUN: read of beat k is issued in a cycle where issued<BEATS && (!out_valid || out_ready).
    - Read data loads the output register the next cycle with out_valid=1.
    - Throughput is 1 beat/cycle while out_ready is held high.
    - When no read is issued and the current beat is consumed, out_valid goes to 0.
  - out_last = out_valid && (beat index == BEATS-1).
  - Handshake of the last beat: next cycle out_valid=0, busy=0, state=IDLE.
- rd_start while in RUN (including the last-handshake cycle) is ignored with no error.
- Reset values: busy=0, out_valid=0, out_last=0, err_range=0, out_data=0, state=IDLE, counters=0.
  - rst mid-stream aborts the stream immediately. Pending beats are discarded.
- rst has priority over simultaneous rd_start/wr_en; the write is not performed.
- The beat counter wraps only through the return to IDLE; never issue beyond BEATS.

Test Plan:
(Defaults: NUM_SV=16, NUM_FEAT=8, LANES=2, BEATS=4. Stream command: rd_start=1, rd_sv=3 in cycle t0.)
- Stream, full throughput: write vector 3 with feature f = 0x300+f; issue the stream command with out_ready=1 -> out_valid=1 in cycles t0+1..t0+4 with out_data {0x301,0x300}, {0x303,0x302}, {0x305,0x304}, {0x307,0x306}; out_last only at t0+4; busy=0 at t0+5.
- Backpressure: same stream with out_ready pattern 0,1,0,1,... -> each beat held stable while stalled; exactly 4 beats in order, no duplicates; out_last on the 4th.
- Range errors: rd_sv=16 -> err_range=1 at t0+1 only; busy and out_valid stay 0. wr_sv=20 -> err_range pulse; a later stream of any vector shows unchanged contents.
- Read-during-write: write vector 3 feature 2 = 0xABC in the same cycle beat 1 is issued -> that beat returns 0x302; a following stream returns 0xABC.
- Reset mid-stream: assert rst after beat 1 handshakes -> next cycle out_valid=0, busy=0; a new rd_start streams correct, preserved data.
- Start while busy: rd_start with rd_sv=5 during the vector-3 stream -> ignored; only vector 3's 4 beats appear; err_range stays 0.

Source files
------------

// File: rtl/sv_stream_mem.sv
// Support-vector store: LANES-banked feature memory with independent write
// port and a valid/ready streaming read port delivering one vector per start.
module sv_stream_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SV     = 16,
  parameter int NUM_FEAT   = 8,
  parameter int LANES      = 2,
  parameter int SV_W       = $clog2(NUM_SV),
  parameter int FEAT_W     = $clog2(NUM_FEAT),
  parameter int BEATS      = NUM_FEAT / LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [SV_W-1:0]             wr_sv,
  input  logic [FEAT_W-1:0]           wr_feat,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_start,
  input  logic [SV_W-1:0]             rd_sv,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        err_range
);

  localparam int ROWS = NUM_SV * BEATS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BKW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW   = $clog2(BEATS + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [SV_W-1:0] sv_q, sv_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            wr_in, wr_ok;
  logic [BKW-1:0]  wr_bank;
  logic [RW-1:0]   wr_row;
  logic            rd_issue;
  logic [RW-1:0]   rd_row;
  logic            last;

  assign last      = valid_q && (beat_q == CW'(BEATS - 1));
  assign busy      = (state_q == S_RUN);
  assign out_valid = valid_q;
  assign out_last  = last;
  assign err_range = err_q;

  // Write address decode and range qualification
  always_comb begin
    wr_in   = (int'(wr_sv) < NUM_SV) && (int'(wr_feat) < NUM_FEAT);
    wr_ok   = wr_en && wr_in && !rst;
    wr_bank = BKW'(int'(wr_feat) % LANES);
    wr_row  = RW'(int'(wr_sv) * BEATS + int'(wr_feat) / LANES);
  end

  // Stream FSM: next state, read issue and beat bookkeeping
  always_comb begin
    state_d  = state_q;
    sv_d     = sv_q;
    issued_d = issued_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    err_d    = wr_en && !wr_in;
    rd_issue = 1'b0;
    rd_row   = '0;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          if (int'(rd_sv) < NUM_SV) begin
            sv_d     = rd_sv;
            rd_issue = 1'b1;
            rd_row   = RW'(int'(rd_sv) * BEATS);
            issued_d = CW'(1);
            beat_d   = '0;
            valid_d  = 1'b1;
            state_d  = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (last && out_ready) begin
          state_d  = S_IDLE;
          issued_d = '0;
          beat_d   = '0;
          valid_d  = 1'b0;
        end else if ((int'(issued_q) < BEATS) && (!valid_q || out_ready)) begin
          // The bank read registers double as the output register, so a read
          // is only issued once the beat currently held has been consumed.
          rd_issue = 1'b1;
          rd_row   = RW'(int'(sv_q) * BEATS + int'(issued_q));
          issued_d = issued_q + CW'(1);
          beat_d   = issued_q;
          valid_d  = 1'b1;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sv_q     <= '0;
      issued_q <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sv_q     <= sv_d;
      issued_q <= issued_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Bank write port; array is never reset
    always_ff @(posedge clk) begin
      if (wr_ok && (wr_bank == BKW'(b))) begin
        mem[wr_row] <= wr_data;
      end
    end

    // Bank read port (old data on same-row write), held while stalled
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_issue) begin
        rdata_q <= mem[rd_row];
      end
    end

    assign out_data[b*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
  end

endmodule

// File: tb/tb_sv_stream_mem.sv
// Directed self-checking bench for sv_stream_mem (SV_W widened to 5 so that
// out-of-range vector indices can be driven).
module tb_sv_stream_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_sv;
  logic [2:0]  wr_feat;
  logic [31:0] wr_data;
  logic        rd_start;
  logic [4:0]  rd_sv;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        err_range;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [16][8];

  always #5 clk = ~clk;

  sv_stream_mem #(
    .DATA_WIDTH(32),
    .NUM_SV(16),
    .NUM_FEAT(8),
    .LANES(2),
    .SV_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_sv(wr_sv),
    .wr_feat(wr_feat),
    .wr_data(wr_data),
    .rd_start(rd_start),
    .rd_sv(rd_sv),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .err_range(err_range)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] sv, input logic [2:0] f, input logic [31:0] d);
    wr_en = 1'b1; wr_sv = sv; wr_feat = f; wr_data = d;
    step();
    wr_en = 1'b0;
    if (sv < 5'd16) model[sv][f] = d;
  endtask

  // Start a stream of vector sv and collect its beats against the model.
  task automatic stream_chk(input string tag, input logic [4:0] sv, input bit stall, input bit inject);
    int          n = 0;
    bit          pstall = 1'b0;
    logic [63:0] pd = '0;
    logic        pl = 1'b0;
    rd_start = 1'b1; rd_sv = sv; out_ready = !stall;
    step();
    rd_start = 1'b0;
    for (int cyc = 1; cyc < 40 && n < 4; cyc++) begin
      out_ready = stall ? (cyc % 2 == 1) : 1'b1;
      check_eq({tag, "_busy"}, busy, 1);
      if (inject) check_eq({tag, "_err"}, err_range, 0);
      if (inject && cyc == 2) begin rd_start = 1'b1; rd_sv = 5'd5; end
      if (pstall) begin
        check_eq({tag, "_hold_data"}, out_data, pd);
        check_eq({tag, "_hold_last"}, out_last, pl);
      end
      if (out_valid && out_ready) begin
        check_eq({tag, "_data"}, out_data, {model[sv][2*n+1], model[sv][2*n]});
        check_eq({tag, "_last"}, out_last, (n == 3));
        if (inject && n == 3) begin rd_start = 1'b1; rd_sv = 5'd5; end
        n++;
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      step();
      rd_start = 1'b0;
    end
    check_eq({tag, "_beats"}, n, 4);
    check_eq({tag, "_end_valid"}, out_valid, 0);
    check_eq({tag, "_end_busy"}, busy, 0);
    if (inject) check_eq({tag, "_end_err"}, err_range, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sv = '0; wr_feat = '0; wr_data = '0;
    rd_start = 1'b0; rd_sv = '0; out_ready = 1'b1;
    for (int s = 0; s < 16; s++)
      for (int f = 0; f < 8; f++) model[s][f] = 'x;
    step();
    step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_err", err_range, 0);
    check_eq("rst_data", out_data, 0);
    rst = 1'b0;

    for (int f = 0; f < 8; f++) begin
      wr(5'd3, 3'(f), 32'h300 + 32'(f));
      wr(5'd4, 3'(f), 32'h400 + 32'(f));
    end

    stream_chk("full", 5'd3, 1'b0, 1'b0);
    stream_chk("bp", 5'd3, 1'b1, 1'b0);

    // Out-of-range stream request
    rd_start = 1'b1; rd_sv = 5'd16;
    step();
    rd_start = 1'b0;
    check_eq("bad_rd_err", err_range, 1);
    check_eq("bad_rd_busy", busy, 0);
    check_eq("bad_rd_valid", out_valid, 0);
    step();
    check_eq("bad_rd_err_pulse", err_range, 0);
    check_eq("bad_rd_busy2", busy, 0);

    // Out-of-range write must not alias onto any stored vector
    wr(5'd20, 3'd1, 32'hDEAD);
    check_eq("bad_wr_err", err_range, 1);
    step();
    check_eq("bad_wr_err_pulse", err_range, 0);
    stream_chk("bad_wr_v4", 5'd4, 1'b0, 1'b0);
    stream_chk("bad_wr_v3", 5'd3, 1'b0, 1'b0);

    // Write to the row being read in the same cycle returns old data
    rd_start = 1'b1; rd_sv = 5'd3;
    step();
    rd_start = 1'b0;
    check_eq("rdw_b0", out_data, {32'h301, 32'h300});
    wr_en = 1'b1; wr_sv = 5'd3; wr_feat = 3'd2; wr_data = 32'hABC;
    step();
    wr_en = 1'b0;
    check_eq("rdw_b1_old", out_data, {32'h303, 32'h302});
    step();
    check_eq("rdw_b2", out_data, {32'h305, 32'h304});
    step();
    check_eq("rdw_b3", out_data, {32'h307, 32'h306});
    check_eq("rdw_b3_last", out_last, 1);
    step();
    check_eq("rdw_end_valid", out_valid, 0);
    model[3][2] = 32'hABC;
    stream_chk("rdw_new", 5'd3, 1'b0, 1'b0);

    // Reset after beat 1 handshakes; a write under reset is discarded
    rd_start = 1'b1; rd_sv = 5'd3;
    step();
    rd_start = 1'b0;
    step();
    check_eq("mid_b1", out_data, {32'h303, 32'hABC});
    step();
    rst = 1'b1;
    wr_en = 1'b1; wr_sv = 5'd3; wr_feat = 3'd0; wr_data = 32'hDEAD;
    step();
    rst = 1'b0;
    wr_en = 1'b0;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_last", out_last, 0);
    check_eq("mid_rst_data", out_data, 0);
    stream_chk("post_rst", 5'd3, 1'b0, 1'b0);

    // Start requests while streaming are ignored
    stream_chk("busy_start", 5'd3, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
